// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank.
package spi_reg_pkg;

  // Register address width carried in the low seven bits of the address byte.
  localparam int ADDR_W = 7;

  // First address of the read-only status window.
  localparam logic [ADDR_W-1:0] STAT_BASE = 7'h40;

  // Frame-level states of the slave.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOAD,
    S_DATA,
    S_COMMIT
  } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings spi_clk and spi_cs into the system clock domain and turns them into
// single-cycle sample/shift edge strobes plus chip-select level and rise.
module spi_edge_sync #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic theClock,
  input  logic theReset,
  input  logic spi_clk,
  input  logic spi_cs,
  output logic sample_edge,
  output logic shift_edge,
  output logic cs_active,
  output logic cs_rise
);

  // [0],[1] are the synchroniser pair; [2] is the previous synced value.
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic       lead_edge;
  logic       trail_edge;

  // Synchroniser and history flops. The CS chain resets to "selected" so that
  // a frame can only start after CS has genuinely been observed high.
  // NOTE: sequential logic uses non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      sck_q <= {3{CPOL}};
      cs_q  <= 3'b000;
    end else begin
      sck_q <= {sck_q[1:0], spi_clk};
      cs_q  <= {cs_q[1:0], spi_cs};
    end
  end

  assign lead_edge   = (sck_q[2] == CPOL) && (sck_q[1] != CPOL);
  assign trail_edge  = (sck_q[2] != CPOL) && (sck_q[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_active   = ~cs_q[1];
  assign cs_rise     = cs_q[1] & ~cs_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI slave register bank: an address byte (W flag + 7-bit address) followed
// by a burst of DATA_W-bit words with address auto-increment. Config words are
// read/write, status words are read-only, everything else reads as zero.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               N_CFG   = 4,
  parameter int               N_STAT  = 8,
  parameter bit               CPOL    = 1'b0,
  parameter bit               CPHA    = 1'b0,
  parameter logic [DATA_W-1:0] CFG_RST = '0,
  localparam int              IDX_W   = (N_CFG > 1) ? $clog2(N_CFG) : 1
) (
  input  logic                     theClock,
  input  logic                     theReset,
  input  logic                     spi_clk,
  input  logic                     spi_cs,
  input  logic                     spi_sdi,
  output logic                     spi_sdo,
  output logic [N_CFG*DATA_W-1:0]  cfg,
  input  logic [N_STAT*DATA_W-1:0] stat,
  output logic                     cfg_wr_stb,
  output logic [IDX_W-1:0]         cfg_wr_idx,
  output logic                     frame_err
);

  // Wide enough to count 8 address bits or up to 32 data bits.
  localparam int               CNT_W     = 6;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic sample_edge;
  logic shift_edge;
  logic cs_active;
  logic cs_rise;

  spi_edge_sync #(
    .CPOL(CPOL),
    .CPHA(CPHA)
  ) u_sync (
    .theClock   (theClock),
    .theReset   (theReset),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .sample_edge(sample_edge),
    .shift_edge (shift_edge),
    .cs_active  (cs_active),
    .cs_rise    (cs_rise)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                sdo_q, sdo_d;
  logic                armed_q, armed_d;
  logic                stb_q, stb_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ferr_q, ferr_d;
  logic                cfg_we;
  logic                cfg_hit;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   cfg_q [N_CFG];

  // Read value at the current address: config word, status word or zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_CFG; i++) begin
      if (int'(addr_q) == i) rd_word = cfg_q[i];
    end
    for (int j = 0; j < N_STAT; j++) begin
      if (int'(addr_q) == int'(STAT_BASE) + j) rd_word = stat[j*DATA_W +: DATA_W];
    end
  end

  assign cfg_hit = int'(addr_q) < N_CFG;

  // Frame FSM next-state and datapath: address capture, word shifting, commit.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    shreg_d = shreg_q;
    sdo_d   = sdo_q;
    armed_d = armed_q | ~cs_active;
    stb_d   = 1'b0;
    idx_d   = idx_q;
    ferr_d  = 1'b0;
    cfg_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        sdo_d = 1'b0;
        cnt_d = '0;
        if (cs_active && armed_q) begin
          armed_d = 1'b0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        sdo_d = 1'b0;
        if (sample_edge) begin
          shreg_d = {shreg_q[DATA_W-2:0], spi_sdi};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            wr_d    = shreg_q[6];
            addr_d  = {shreg_q[5:0], spi_sdi};
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        shreg_d = rd_word;
        cnt_d   = '0;
        // With CPHA=0 the master samples the MSB on the very next edge, so it
        // must already be on the line; with CPHA=1 the first shift edge does it.
        if (!CPHA) sdo_d = rd_word[DATA_W-1];
        state_d = S_DATA;
      end

      S_DATA: begin
        if (sample_edge) begin
          shreg_d = {shreg_q[DATA_W-2:0], spi_sdi};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) state_d = S_COMMIT;
        end else if (shift_edge && (CPHA || cnt_q != '0)) begin
          // For CPHA=0 the shift edge before the first sample of a word would
          // skip the MSB that LOAD already presented, so it is ignored.
          sdo_d = shreg_q[DATA_W-1];
        end
      end

      S_COMMIT: begin
        if (wr_q && cfg_hit) begin
          cfg_we = 1'b1;
          stb_d  = 1'b1;
          idx_d  = addr_q[IDX_W-1:0];
        end
        addr_d  = addr_q + 1'b1;
        state_d = S_LOAD;
      end

      default: state_d = S_IDLE;
    endcase

    // Deselect overrides everything except a commit already decided above.
    if (cs_rise) begin
      ferr_d  = (state_q == S_ADDR || state_q == S_DATA) && (cnt_q != '0);
      sdo_d   = 1'b0;
      state_d = S_IDLE;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      shreg_q <= '0;
      sdo_q   <= 1'b0;
      armed_q <= 1'b0;
      stb_q   <= 1'b0;
      idx_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
      armed_q <= armed_d;
      stb_q   <= stb_d;
      idx_q   <= idx_d;
      ferr_q  <= ferr_d;
    end
  end

  // Config word storage, written one word per COMMIT.
  // NOTE: the config array is built from flops rather than a RAM macro, so it
  // takes the async reset and comes up at CFG_RST like any other register.
  always_ff @(posedge theClock or posedge theReset) begin
    if (theReset) begin
      for (int i = 0; i < N_CFG; i++) cfg_q[i] <= CFG_RST;
    end else if (cfg_we) begin
      for (int i = 0; i < N_CFG; i++) begin
        if (int'(addr_q) == i) cfg_q[i] <= shreg_q;
      end
    end
  end

  for (genvar g = 0; g < N_CFG; g++) begin : g_cfg_pack
    assign cfg[g*DATA_W +: DATA_W] = cfg_q[g];
  end

  assign spi_sdo    = sdo_q;
  assign cfg_wr_stb = stb_q;
  assign cfg_wr_idx = idx_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: one 8-bit mode-0 instance plus 16-bit
// instances for modes 1, 2 and 3, driven by a shared bit-banged SPI master.
module tb_spi_reg_bank;

  localparam int HP = 80;  // SPI half period: 8 system clocks

  logic         theClock;
  logic         theReset;
  logic         ph;          // master clock phase, 1 = leading half
  logic         sdi;
  logic [3:0]   cs;
  logic [3:0]   sck;
  logic [3:0]   sdo;
  logic [3:0]   stb;
  logic [3:0]   ferr;
  logic [1:0]   idx [4];
  logic [31:0]  cfg8;
  logic [63:0]  cfg16 [1:3];
  logic [63:0]  stat8;
  logic [127:0] stat16;

  int          sel;
  logic        cpha_sel;
  int          errors;
  int          checks;
  int          stb_cnt;
  int          ferr_cnt;
  logic [1:0]  idx_log [64];
  logic [15:0] tx_w [8];
  logic [15:0] rx_w [8];

  assign sck[0] = ph;
  assign sck[1] = ph;
  assign sck[2] = ~ph;
  assign sck[3] = ~ph;

  spi_reg_bank #(.DATA_W(8), .N_CFG(4), .N_STAT(8), .CPOL(1'b0), .CPHA(1'b0),
                 .CFG_RST(8'h00)) u_m0 (
    .theClock(theClock), .theReset(theReset), .spi_clk(sck[0]), .spi_cs(cs[0]),
    .spi_sdi(sdi), .spi_sdo(sdo[0]), .cfg(cfg8), .stat(stat8),
    .cfg_wr_stb(stb[0]), .cfg_wr_idx(idx[0]), .frame_err(ferr[0]));

  spi_reg_bank #(.DATA_W(16), .N_CFG(4), .N_STAT(8), .CPOL(1'b0), .CPHA(1'b1),
                 .CFG_RST(16'h1234)) u_m1 (
    .theClock(theClock), .theReset(theReset), .spi_clk(sck[1]), .spi_cs(cs[1]),
    .spi_sdi(sdi), .spi_sdo(sdo[1]), .cfg(cfg16[1]), .stat(stat16),
    .cfg_wr_stb(stb[1]), .cfg_wr_idx(idx[1]), .frame_err(ferr[1]));

  spi_reg_bank #(.DATA_W(16), .N_CFG(4), .N_STAT(8), .CPOL(1'b1), .CPHA(1'b0),
                 .CFG_RST(16'h1234)) u_m2 (
    .theClock(theClock), .theReset(theReset), .spi_clk(sck[2]), .spi_cs(cs[2]),
    .spi_sdi(sdi), .spi_sdo(sdo[2]), .cfg(cfg16[2]), .stat(stat16),
    .cfg_wr_stb(stb[2]), .cfg_wr_idx(idx[2]), .frame_err(ferr[2]));

  spi_reg_bank #(.DATA_W(16), .N_CFG(4), .N_STAT(8), .CPOL(1'b1), .CPHA(1'b1),
                 .CFG_RST(16'h1234)) u_m3 (
    .theClock(theClock), .theReset(theReset), .spi_clk(sck[3]), .spi_cs(cs[3]),
    .spi_sdi(sdi), .spi_sdo(sdo[3]), .cfg(cfg16[3]), .stat(stat16),
    .cfg_wr_stb(stb[3]), .cfg_wr_idx(idx[3]), .frame_err(ferr[3]));

  initial theClock = 1'b0;
  always #5 theClock = ~theClock;

  // Record strobes and frame errors of the selected instance, away from posedge.
  always @(negedge theClock) begin
    if (stb[sel] === 1'b1) begin
      idx_log[stb_cnt % 64] = idx[sel];
      stb_cnt = stb_cnt + 1;
    end
    if (ferr[sel] === 1'b1) ferr_cnt = ferr_cnt + 1;
  end

  // One SPI bit: drive b, return what the slave presented at the sample edge.
  task automatic sck_bit(input logic b, output logic r);
    if (!cpha_sel) begin
      sdi = b;
      #HP;
      r  = sdo[sel];
      ph = 1'b1;
      #HP;
      ph = 1'b0;
    end else begin
      ph  = 1'b1;
      sdi = b;
      #HP;
      r  = sdo[sel];
      ph = 1'b0;
      #HP;
    end
  endtask

  task automatic xfer_word(input int w, input logic [15:0] d, input int nbits,
                           output logic [15:0] r);
    logic rb;
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      sck_bit(d[w-1-i], rb);
      r = {r[14:0], rb};
    end
  endtask

  // Full frame: header, nw words from tx_w into rx_w, optional partial word.
  task automatic frame(input int w, input logic [7:0] hdr, input int nw,
                       input int abort_bits);
    logic [15:0] dummy;
    @(negedge theClock);
    cs[sel] = 1'b0;
    #HP;
    xfer_word(8, {8'h00, hdr}, 8, dummy);
    for (int k = 0; k < nw; k++) xfer_word(w, tx_w[k], w, rx_w[k]);
    if (abort_bits > 0) xfer_word(w, tx_w[nw], abort_bits, dummy);
    #HP;
    cs[sel] = 1'b1;
    sdi = 1'b0;
    #(2*HP);
  endtask

  task automatic test_reset();
    checks++; if (cfg8 !== 32'h0) begin errors++;
      $display("FAIL reset_cfg8: got %h expected %h", cfg8, 32'h0); end
    checks++; if (cfg16[2] !== {4{16'h1234}}) begin errors++;
      $display("FAIL reset_cfg16: got %h expected %h", cfg16[2], {4{16'h1234}}); end
    checks++; if (sdo !== 4'h0) begin errors++;
      $display("FAIL reset_sdo: got %b expected 0000", sdo); end
    checks++; if (stb !== 4'h0) begin errors++;
      $display("FAIL reset_stb: got %b expected 0000", stb); end
    checks++; if (ferr !== 4'h0) begin errors++;
      $display("FAIL reset_ferr: got %b expected 0000", ferr); end
  endtask

  task automatic test_read();
    int sb, fb;
    sb = stb_cnt; fb = ferr_cnt;
    frame(8, 8'h40, 2, 0);
    checks++; if (rx_w[0] !== 16'h00A5) begin errors++;
      $display("FAIL read_stat0: got %h expected %h", rx_w[0], 16'h00A5); end
    checks++; if (rx_w[1] !== 16'h003C) begin errors++;
      $display("FAIL read_stat1_burst: got %h expected %h", rx_w[1], 16'h003C); end
    checks++; if (ferr_cnt - fb !== 0) begin errors++;
      $display("FAIL read_ferr: got %0d expected 0", ferr_cnt - fb); end
    checks++; if (stb_cnt - sb !== 0) begin errors++;
      $display("FAIL read_stb: got %0d expected 0", stb_cnt - sb); end
  endtask

  task automatic test_write_burst();
    int sb;
    sb = stb_cnt;
    tx_w[0] = 16'h11; tx_w[1] = 16'h22; tx_w[2] = 16'h33;
    frame(8, 8'h81, 3, 0);
    checks++; if (cfg8 !== 32'h33221100) begin errors++;
      $display("FAIL wr_burst_cfg: got %h expected %h", cfg8, 32'h33221100); end
    checks++; if (stb_cnt - sb !== 3) begin errors++;
      $display("FAIL wr_burst_stb: got %0d expected 3", stb_cnt - sb); end
    checks++; if ({idx_log[sb], idx_log[sb+1], idx_log[sb+2]} !== 6'b01_10_11) begin errors++;
      $display("FAIL wr_burst_idx: got %b expected 011011",
               {idx_log[sb], idx_log[sb+1], idx_log[sb+2]}); end
    frame(8, 8'h01, 3, 0);
    checks++; if ({rx_w[0], rx_w[1], rx_w[2]} !== 48'h0011_0022_0033) begin errors++;
      $display("FAIL wr_burst_readback: got %h expected %h",
               {rx_w[0], rx_w[1], rx_w[2]}, 48'h0011_0022_0033); end
  endtask

  task automatic test_unmapped();
    int sb;
    sb = stb_cnt;
    tx_w[0] = 16'h44; tx_w[1] = 16'h55;
    frame(8, 8'h83, 2, 0);
    checks++; if (rx_w[0] !== 16'h0033) begin errors++;
      $display("FAIL unmapped_old_value: got %h expected %h", rx_w[0], 16'h0033); end
    checks++; if (cfg8 !== 32'h44221100) begin errors++;
      $display("FAIL unmapped_cfg: got %h expected %h", cfg8, 32'h44221100); end
    checks++; if (stb_cnt - sb !== 1) begin errors++;
      $display("FAIL unmapped_stb: got %0d expected 1", stb_cnt - sb); end
    checks++; if (idx_log[sb] !== 2'd3) begin errors++;
      $display("FAIL unmapped_idx: got %0d expected 3", idx_log[sb]); end
    frame(8, 8'h04, 1, 0);
    checks++; if (rx_w[0] !== 16'h0000) begin errors++;
      $display("FAIL unmapped_read: got %h expected 0000", rx_w[0]); end
  endtask

  task automatic test_wrap();
    int sb;
    sb = stb_cnt;
    tx_w[0] = 16'hAA; tx_w[1] = 16'h9C;
    frame(8, 8'hFF, 2, 0);
    checks++; if (cfg8 !== 32'h4422119C) begin errors++;
      $display("FAIL wrap_cfg: got %h expected %h", cfg8, 32'h4422119C); end
    checks++; if (stb_cnt - sb !== 1) begin errors++;
      $display("FAIL wrap_stb: got %0d expected 1", stb_cnt - sb); end
    checks++; if (idx_log[sb] !== 2'd0) begin errors++;
      $display("FAIL wrap_idx: got %0d expected 0", idx_log[sb]); end
  endtask

  task automatic test_abort();
    int sb, fb;
    sb = stb_cnt; fb = ferr_cnt;
    tx_w[0] = 16'hFF;
    frame(8, 8'h80, 0, 5);
    checks++; if (cfg8 !== 32'h4422119C) begin errors++;
      $display("FAIL abort_cfg: got %h expected %h", cfg8, 32'h4422119C); end
    checks++; if (ferr_cnt - fb !== 1) begin errors++;
      $display("FAIL abort_ferr: got %0d expected 1", ferr_cnt - fb); end
    checks++; if (stb_cnt - sb !== 0) begin errors++;
      $display("FAIL abort_stb: got %0d expected 0", stb_cnt - sb); end
    checks++; if (sdo[0] !== 1'b0) begin errors++;
      $display("FAIL abort_sdo_idle: got %b expected 0", sdo[0]); end
  endtask

  task automatic test_modes();
    int sb, fb;
    for (int k = 1; k < 4; k++) begin
      sel = k;
      cpha_sel = (k == 1 || k == 3);
      sb = stb_cnt; fb = ferr_cnt;
      frame(16, 8'h40, 2, 0);
      checks++; if ({rx_w[0], rx_w[1]} !== 32'hBEEF_CAFE) begin errors++;
        $display("FAIL mode%0d_read: got %h expected %h", k, {rx_w[0], rx_w[1]},
                 32'hBEEF_CAFE); end
      tx_w[0] = 16'h1111; tx_w[1] = 16'h2222; tx_w[2] = 16'h3333;
      frame(16, 8'h81, 3, 0);
      checks++; if (cfg16[k] !== 64'h3333_2222_1111_1234) begin errors++;
        $display("FAIL mode%0d_cfg: got %h expected %h", k, cfg16[k],
                 64'h3333_2222_1111_1234); end
      checks++; if (stb_cnt - sb !== 3) begin errors++;
        $display("FAIL mode%0d_stb: got %0d expected 3", k, stb_cnt - sb); end
      checks++; if ({idx_log[sb], idx_log[sb+1], idx_log[sb+2]} !== 6'b01_10_11) begin errors++;
        $display("FAIL mode%0d_idx: got %b expected 011011", k,
                 {idx_log[sb], idx_log[sb+1], idx_log[sb+2]}); end
      checks++; if (ferr_cnt - fb !== 0) begin errors++;
        $display("FAIL mode%0d_ferr: got %0d expected 0", k, ferr_cnt - fb); end
    end
    sel = 0;
    cpha_sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int sb, fb;
    logic [15:0] d;
    tx_w[0] = 16'h5A;
    frame(8, 8'h80, 1, 0);
    checks++; if (cfg8[7:0] !== 8'h5A) begin errors++;
      $display("FAIL rstmid_pre_write: got %h expected 5a", cfg8[7:0]); end
    // Start a burst write and reset it three bits into the first data word.
    @(negedge theClock);
    cs[0] = 1'b0;
    #HP;
    xfer_word(8, 16'h0080, 8, d);
    xfer_word(8, 16'h00C3, 3, d);
    theReset = 1'b1;
    #1;
    checks++; if (cfg8 !== 32'h0) begin errors++;
      $display("FAIL rstmid_cfg_cleared: got %h expected %h", cfg8, 32'h0); end
    #20;
    @(negedge theClock);
    theReset = 1'b0;
    sb = stb_cnt; fb = ferr_cnt;
    // CS never went high: these bits must not be taken as a new frame.
    xfer_word(8, 16'h0080, 8, d);
    xfer_word(8, 16'h0077, 8, d);
    #HP;
    cs[0] = 1'b1;
    sdi = 1'b0;
    #(2*HP);
    checks++; if (cfg8 !== 32'h0) begin errors++;
      $display("FAIL rstmid_no_restart: got %h expected %h", cfg8, 32'h0); end
    checks++; if (stb_cnt - sb !== 0 || ferr_cnt - fb !== 0) begin errors++;
      $display("FAIL rstmid_no_events: got stb=%0d ferr=%0d expected 0 0",
               stb_cnt - sb, ferr_cnt - fb); end
    tx_w[0] = 16'h3C;
    frame(8, 8'h80, 1, 0);
    checks++; if (cfg8 !== 32'h0000003C) begin errors++;
      $display("FAIL rstmid_next_frame: got %h expected %h", cfg8, 32'h0000003C); end
    checks++; if (stb_cnt - sb !== 1) begin errors++;
      $display("FAIL rstmid_next_stb: got %0d expected 1", stb_cnt - sb); end
  endtask

  initial begin
    theReset = 1'b1;
    cs       = 4'hF;
    ph       = 1'b0;
    sdi      = 1'b0;
    sel      = 0;
    cpha_sel = 1'b0;
    errors   = 0;
    checks   = 0;
    stb_cnt  = 0;
    ferr_cnt = 0;
    stat8    = {48'h0, 8'h3C, 8'hA5};
    stat16   = {96'h0, 16'hCAFE, 16'hBEEF};
    #23;
    @(negedge theClock);
    test_reset();
    theReset = 1'b0;
    #50;
    test_read();
    test_write_burst();
    test_unmapped();
    test_wrap();
    test_abort();
    test_modes();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
